// File: rtl/aoc25_5_pkg.sv
// ---------------------------------------------------------------------------
// aoc25_5_pkg
//   Definitions shared by the day-5 cafeteria input decoder and the
//   range-match/count stage downstream of it.
//
//   Contents:
//     DEFAULT_VALUE_WIDTH / DEFAULT_COUNT_WIDTH
//         Default widths for decoded values and record counters.
//     parser_state_t
//         The parser states RANGE_LO, RANGE_HI, IDS and DONE.
//     CHAR_LF, CHAR_CR, CHAR_DASH, CHAR_ZERO, CHAR_NINE
//         The ASCII codes that the parser reacts to.
//     range_t
//         One inclusive range {lo, hi}. It is used by the match stage.
//     is_digit()
//         Returns true for the ASCII characters '0' to '9'.
// ---------------------------------------------------------------------------
package aoc25_5_pkg;

  localparam int DEFAULT_VALUE_WIDTH = 64;
  localparam int DEFAULT_COUNT_WIDTH = 16;

  typedef enum logic [1:0] {
    RANGE_LO = 2'd0,
    RANGE_HI = 2'd1,
    IDS      = 2'd2,
    DONE     = 2'd3
  } parser_state_t;

  localparam logic [7:0] CHAR_LF   = 8'h0A;
  localparam logic [7:0] CHAR_CR   = 8'h0D;
  localparam logic [7:0] CHAR_DASH = 8'h2D;
  localparam logic [7:0] CHAR_ZERO = 8'h30;
  localparam logic [7:0] CHAR_NINE = 8'h39;

  typedef struct packed {
    logic [DEFAULT_VALUE_WIDTH-1:0] lo;
    logic [DEFAULT_VALUE_WIDTH-1:0] hi;
  } range_t;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CHAR_ZERO) && (c <= CHAR_NINE);
  endfunction

endpackage

// File: rtl/cafeteria_input_decoder_if.sv
// ---------------------------------------------------------------------------
// cafeteria_input_decoder_if
//   Groups the signals between the byte source, the decoder and the
//   record consumer.
//
//   Byte stream (source -> decoder):
//     byte_valid, byte_data[7:0], end_of_input
//   Records (decoder -> consumer):
//     range_valid, range_lo, range_hi  : one completed inclusive range
//     id_valid, id_value               : one completed ingredient ID
//   Status (decoder -> consumer):
//     ranges_done, done, range_count, id_count, error
//
//   Modports:
//     slave  : the decoder side. It takes bytes in and drives records out.
//     master : the environment side. It drives bytes and observes records.
// ---------------------------------------------------------------------------
interface cafeteria_input_decoder_if
  import aoc25_5_pkg::*;
#(
  parameter int VALUE_WIDTH = DEFAULT_VALUE_WIDTH,
  parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
);

  logic                   byte_valid;
  logic [7:0]             byte_data;
  logic                   end_of_input;

  logic                   range_valid;
  logic [VALUE_WIDTH-1:0] range_lo;
  logic [VALUE_WIDTH-1:0] range_hi;
  logic                   id_valid;
  logic [VALUE_WIDTH-1:0] id_value;

  logic                   ranges_done;
  logic                   done;
  logic [COUNT_WIDTH-1:0] range_count;
  logic [COUNT_WIDTH-1:0] id_count;
  logic                   error;

  modport slave (
    input  byte_valid, byte_data, end_of_input,
    output range_valid, range_lo, range_hi, id_valid, id_value,
    output ranges_done, done, range_count, id_count, error
  );

  modport master (
    output byte_valid, byte_data, end_of_input,
    input  range_valid, range_lo, range_hi, id_valid, id_value,
    input  ranges_done, done, range_count, id_count, error
  );

endinterface

// File: rtl/decimal_accumulator.sv
// ---------------------------------------------------------------------------
// decimal_accumulator
//   Builds a decimal value one digit at a time: acc = acc*10 + digit.
//   The result saturates to all-ones when it overflows.
//
//   Ports:
//     tck         in   clock
//     reset       in   synchronous, active-high reset
//     digit_valid in   apply 'digit' this cycle
//     digit       in   value of the digit, 0 to 9
//     clear       in   set the register to zero at the end of this cycle;
//                      this takes priority over the digit update
//     acc         out  current registered value
//     acc_step    out  value after this cycle's digit is applied, before
//                      clear. The parser reads it when a record ends in the
//                      same cycle as the last digit.
//     overflow    out  this cycle's digit pushed the value past VALUE_WIDTH
// ---------------------------------------------------------------------------
module decimal_accumulator
  import aoc25_5_pkg::*;
#(
  parameter int VALUE_WIDTH = DEFAULT_VALUE_WIDTH
) (
  input  logic                   tck,
  input  logic                   reset,
  input  logic                   digit_valid,
  input  logic [3:0]             digit,
  input  logic                   clear,
  output logic [VALUE_WIDTH-1:0] acc,
  output logic [VALUE_WIDTH-1:0] acc_step,
  output logic                   overflow
);

  logic [VALUE_WIDTH-1:0] acc_reg;
  logic [VALUE_WIDTH-1:0] acc_next;
  logic [VALUE_WIDTH+3:0] wide;

  // x*10 is computed as x*8 + x*2. Four extra bits are enough to hold
  // (2^W - 1)*10 + 9, so every overflow shows up in the top nibble.
  // A saturated all-ones value overflows again on any further digit, so it
  // stays at all-ones.
  always_comb begin
    wide     = ({4'b0000, acc_reg} << 3) + ({4'b0000, acc_reg} << 1)
             + {{VALUE_WIDTH{1'b0}}, digit};
    overflow = 1'b0;
    acc_step = acc_reg;
    if (digit_valid) begin
      if (|wide[VALUE_WIDTH+3:VALUE_WIDTH]) begin
        overflow = 1'b1;
        acc_step = '1;
      end else begin
        acc_step = wide[VALUE_WIDTH-1:0];
      end
    end
    acc_next = clear ? '0 : acc_step;
  end

  always_ff @(posedge tck) begin
    if (reset) begin
      acc_reg <= '0;
    end else begin
      acc_reg <= acc_next;
    end
  end

  assign acc = acc_reg;

endmodule

// File: rtl/cafeteria_input_decoder.sv
// ---------------------------------------------------------------------------
// cafeteria_input_decoder
//   Parses the day-5 puzzle text. The input is a list of "lo-hi" ranges,
//   a blank line, and then one ingredient ID per line. The block emits one
//   range record or ID record per completed line.
//
//   Ports:
//     tck    in   design clock (JTAG TCK domain)
//     reset  in   synchronous, active-high reset
//     bus    slave modport of cafeteria_input_decoder_if:
//              byte_valid/byte_data/end_of_input      byte stream in
//              range_valid/range_lo/range_hi          range record out
//              id_valid/id_value                      ID record out
//              ranges_done, done                      progress levels
//              range_count, id_count                  saturating counters
//              error                                  sticky error flag
//
//   Every record strobe is registered, so it appears one cycle after the
//   byte (or end_of_input) that completes the record. A byte is accepted on
//   every cycle.
// ---------------------------------------------------------------------------
module cafeteria_input_decoder
  import aoc25_5_pkg::*;
#(
  parameter int VALUE_WIDTH = DEFAULT_VALUE_WIDTH,
  parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
  input logic                      tck,
  input logic                      reset,
  cafeteria_input_decoder_if.slave bus
);

  // State and output registers.
  parser_state_t          state_reg, state_next;
  logic [VALUE_WIDTH-1:0] lo_reg, lo_next;
  logic                   line_has_digit_reg, line_has_digit_next;
  logic                   eoi_pending_reg, eoi_pending_next;

  logic                   range_valid_reg;
  logic [VALUE_WIDTH-1:0] range_lo_reg;
  logic [VALUE_WIDTH-1:0] range_hi_reg;
  logic                   id_valid_reg;
  logic [VALUE_WIDTH-1:0] id_value_reg;
  logic                   ranges_done_reg;
  logic                   done_reg;
  logic [COUNT_WIDTH-1:0] range_count_reg;
  logic [COUNT_WIDTH-1:0] id_count_reg;
  logic                   error_reg;

  // Combinational controls.
  logic                   byte_act;
  logic                   acc_digit;
  logic                   acc_clear;
  logic                   emit_range;
  logic                   emit_id;
  logic                   err_set;
  logic                   rdone_set;
  logic                   done_set;

  logic [VALUE_WIDTH-1:0] acc;
  logic [VALUE_WIDTH-1:0] acc_step;
  logic                   acc_overflow;

  // One accumulator is shared by the lower bound, the upper bound and the
  // IDs. Only one number is ever being built at a time.
  decimal_accumulator #(
    .VALUE_WIDTH (VALUE_WIDTH)
  ) u_acc (
    .tck         (tck),
    .reset       (reset),
    .digit_valid (acc_digit),
    .digit       (bus.byte_data[3:0]),
    .clear       (acc_clear),
    .acc         (acc),
    .acc_step    (acc_step),
    .overflow    (acc_overflow)
  );

  // Next-state logic. The byte is handled first. After that, an
  // end_of_input strobe in the same cycle flushes whatever record the byte
  // left open. Because the flush looks at the post-byte state, a final '\n'
  // that arrives together with end_of_input does not produce a second
  // record.
  always_comb begin
    state_next          = state_reg;
    lo_next             = lo_reg;
    line_has_digit_next = line_has_digit_reg;
    eoi_pending_next    = eoi_pending_reg;
    acc_digit           = 1'b0;
    acc_clear           = 1'b0;
    emit_range          = 1'b0;
    emit_id             = 1'b0;
    err_set             = 1'b0;
    rdone_set           = 1'b0;
    done_set            = 1'b0;

    // Bytes that arrive after end_of_input are ignored.
    byte_act = bus.byte_valid && (state_reg != DONE) && !eoi_pending_reg;

    if (byte_act && (bus.byte_data != CHAR_CR)) begin
      if (is_digit(bus.byte_data)) begin
        acc_digit           = 1'b1;
        line_has_digit_next = 1'b1;
      end else begin
        case (state_reg)
          RANGE_LO: begin
            if (bus.byte_data == CHAR_DASH) begin
              if (line_has_digit_reg) begin
                lo_next             = acc;
                acc_clear           = 1'b1;
                line_has_digit_next = 1'b0;
                state_next          = RANGE_HI;
              end else begin
                err_set = 1'b1;
              end
            end else if (bus.byte_data == CHAR_LF) begin
              if (line_has_digit_reg) begin
                // The line has a number but no '-', so it is dropped.
                err_set             = 1'b1;
                acc_clear           = 1'b1;
                line_has_digit_next = 1'b0;
              end else begin
                rdone_set  = 1'b1;
                state_next = IDS;
              end
            end else begin
              err_set = 1'b1;
            end
          end
          RANGE_HI: begin
            if (bus.byte_data == CHAR_LF) begin
              emit_range          = 1'b1;
              acc_clear           = 1'b1;
              line_has_digit_next = 1'b0;
              state_next          = RANGE_LO;
            end else begin
              err_set = 1'b1;
            end
          end
          IDS: begin
            if (bus.byte_data == CHAR_LF) begin
              // A blank line among the IDs is harmless and produces nothing.
              emit_id             = line_has_digit_reg;
              acc_clear           = 1'b1;
              line_has_digit_next = 1'b0;
            end else begin
              err_set = 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end

    if (bus.end_of_input && (state_reg != DONE) && !eoi_pending_reg) begin
      eoi_pending_next = 1'b1;
      if (state_next == RANGE_HI) begin
        emit_range          = 1'b1;
        acc_clear           = 1'b1;
        line_has_digit_next = 1'b0;
      end else if ((state_next == IDS) && line_has_digit_next) begin
        emit_id             = 1'b1;
        acc_clear           = 1'b1;
        line_has_digit_next = 1'b0;
      end
    end

    // DONE is entered on the cycle after end_of_input.
    if (eoi_pending_reg) begin
      eoi_pending_next = 1'b0;
      state_next       = DONE;
      done_set         = 1'b1;
    end
  end

  always_ff @(posedge tck) begin
    if (reset) begin
      state_reg          <= RANGE_LO;
      lo_reg             <= '0;
      line_has_digit_reg <= 1'b0;
      eoi_pending_reg    <= 1'b0;
      range_valid_reg    <= 1'b0;
      range_lo_reg       <= '0;
      range_hi_reg       <= '0;
      id_valid_reg       <= 1'b0;
      id_value_reg       <= '0;
      ranges_done_reg    <= 1'b0;
      done_reg           <= 1'b0;
      range_count_reg    <= '0;
      id_count_reg       <= '0;
      error_reg          <= 1'b0;
    end else begin
      state_reg          <= state_next;
      lo_reg             <= lo_next;
      line_has_digit_reg <= line_has_digit_next;
      eoi_pending_reg    <= eoi_pending_next;
      range_valid_reg    <= emit_range;
      id_valid_reg       <= emit_id;
      ranges_done_reg    <= ranges_done_reg | rdone_set;
      done_reg           <= done_reg | done_set;
      error_reg          <= error_reg | err_set | acc_overflow;

      // The closing value is taken from acc_step so that a digit arriving
      // together with end_of_input is included in the flushed record.
      // lo_next covers a '-' that arrives in the same cycle as the flush.
      if (emit_range) begin
        range_lo_reg <= lo_next;
        range_hi_reg <= acc_step;
        if (range_count_reg != '1) begin
          range_count_reg <= range_count_reg + 1'b1;
        end
      end
      if (emit_id) begin
        id_value_reg <= acc_step;
        if (id_count_reg != '1) begin
          id_count_reg <= id_count_reg + 1'b1;
        end
      end
    end
  end

  assign bus.range_valid = range_valid_reg;
  assign bus.range_lo    = range_lo_reg;
  assign bus.range_hi    = range_hi_reg;
  assign bus.id_valid    = id_valid_reg;
  assign bus.id_value    = id_value_reg;
  assign bus.ranges_done = ranges_done_reg;
  assign bus.done        = done_reg;
  assign bus.range_count = range_count_reg;
  assign bus.id_count    = id_count_reg;
  assign bus.error       = error_reg;

endmodule

// File: tb/tb_cafeteria_input_decoder.sv
// ---------------------------------------------------------------------------
// tb_cafeteria_input_decoder
//   Runs a table of byte streams through cafeteria_input_decoder.
//   For each stream it collects the emitted records and compares them, the
//   counters and the status levels with hand-computed expectations.
//   The cycle-exact behaviour of end_of_input and of back-to-back bytes is
//   checked inline.
// ---------------------------------------------------------------------------
module tb_cafeteria_input_decoder;
  import aoc25_5_pkg::*;

  localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic tck;
  logic reset;

  initial tck = 1'b0;
  always #5 tck = ~tck;

  cafeteria_input_decoder_if #(.VALUE_WIDTH(64), .COUNT_WIDTH(16)) bus ();

  cafeteria_input_decoder #(
    .VALUE_WIDTH (64),
    .COUNT_WIDTH (16)
  ) dut (
    .tck   (tck),
    .reset (reset),
    .bus   (bus)
  );

  // One case: an optional stream that is followed by a reset, the main
  // stream, the pacing gap, the end_of_input mode (0 none, 1 separate
  // strobe, 2 on the last byte) and the expected results.
  typedef struct {
    string       pre;
    string       stream;
    int          gap;
    int          eoi_mode;
    int          n_rng;
    logic [63:0] rlo [4];
    logic [63:0] rhi [4];
    int          n_id;
    logic [63:0] ids [6];
    bit          exp_err;
    bit          exp_rdone;
  } case_t;

  case_t       cases [12];
  int          n_cases;
  int          checks;
  int          errors;
  range_t      got_rng [$];
  logic [63:0] got_id [$];
  int          stray;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic new_case(input string pre, input string s, input int gap, input int mode,
                          input bit err, input bit rdone);
    cases[n_cases].pre       = pre;
    cases[n_cases].stream    = s;
    cases[n_cases].gap       = gap;
    cases[n_cases].eoi_mode  = mode;
    cases[n_cases].n_rng     = 0;
    cases[n_cases].n_id      = 0;
    cases[n_cases].exp_err   = err;
    cases[n_cases].exp_rdone = rdone;
    n_cases++;
  endtask

  task automatic add_rng(input logic [63:0] lo, input logic [63:0] hi);
    int k;
    k = cases[n_cases-1].n_rng;
    cases[n_cases-1].rlo[k] = lo;
    cases[n_cases-1].rhi[k] = hi;
    cases[n_cases-1].n_rng  = k + 1;
  endtask

  task automatic add_id(input logic [63:0] v);
    int k;
    k = cases[n_cases-1].n_id;
    cases[n_cases-1].ids[k] = v;
    cases[n_cases-1].n_id   = k + 1;
  endtask

  // Collects any strobe visible now. A strobe seen while 'expected' is 0
  // came at the wrong cycle.
  task automatic sample(input bit expected);
    if (bus.range_valid) begin
      got_rng.push_back(range_t'{lo: bus.range_lo, hi: bus.range_hi});
      if (!expected) stray++;
    end
    if (bus.id_valid) begin
      got_id.push_back(bus.id_value);
      if (!expected) stray++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge tck);
      #1;
      sample(1'b0);
    end
  endtask

  task automatic send_byte(input logic [7:0] c, input bit eoi);
    bus.byte_valid   = 1'b1;
    bus.byte_data    = c;
    bus.end_of_input = eoi;
    @(posedge tck);
    #1;
    bus.byte_valid   = 1'b0;
    bus.end_of_input = 1'b0;
    sample(1'b1);
  endtask

  task automatic send_str(input string s, input int gap, input bit eoi_last);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i], eoi_last && (i == s.len() - 1));
      if (!(eoi_last && (i == s.len() - 1))) idle(gap);
    end
  endtask

  task automatic do_reset();
    reset            = 1'b1;
    bus.byte_valid   = 1'b0;
    bus.byte_data    = 8'h00;
    bus.end_of_input = 1'b0;
    repeat (2) @(posedge tck);
    #1;
    reset = 1'b0;
  endtask

  task automatic run_case(input int ci);
    case_t c;
    c = cases[ci];
    got_rng.delete();
    got_id.delete();
    stray = 0;
    do_reset();
    if (c.pre.len() > 0) begin
      send_str(c.pre, c.gap, 1'b0);
      do_reset();
    end
    send_str(c.stream, c.gap, c.eoi_mode == 2);
    if (c.eoi_mode == 1) begin
      bus.end_of_input = 1'b1;
      @(posedge tck);
      #1;
      bus.end_of_input = 1'b0;
      sample(1'b1);
    end
    if (c.eoi_mode != 0) begin
      check64($sformatf("c%0d done_early", ci), 64'(bus.done), 64'd0);
      idle(1);
      check64($sformatf("c%0d done_rise", ci), 64'(bus.done), 64'd1);
      // These bytes arrive in DONE and must be ignored.
      send_str("7-8\n", 0, 1'b0);
    end
    idle(2);

    check64($sformatf("c%0d range_n", ci), 64'(got_rng.size()), 64'(c.n_rng));
    for (int i = 0; i < c.n_rng && i < got_rng.size(); i++) begin
      check64($sformatf("c%0d r%0d_lo", ci, i), got_rng[i].lo, c.rlo[i]);
      check64($sformatf("c%0d r%0d_hi", ci, i), got_rng[i].hi, c.rhi[i]);
    end
    check64($sformatf("c%0d id_n", ci), 64'(got_id.size()), 64'(c.n_id));
    for (int i = 0; i < c.n_id && i < got_id.size(); i++) begin
      check64($sformatf("c%0d id%0d", ci, i), got_id[i], c.ids[i]);
    end
    check64($sformatf("c%0d range_count", ci), 64'(bus.range_count), 64'(c.n_rng));
    check64($sformatf("c%0d id_count", ci), 64'(bus.id_count), 64'(c.n_id));
    check64($sformatf("c%0d error", ci), 64'(bus.error), 64'(c.exp_err));
    check64($sformatf("c%0d ranges_done", ci), 64'(bus.ranges_done), 64'(c.exp_rdone));
    check64($sformatf("c%0d done", ci), 64'(bus.done), 64'(c.eoi_mode != 0));
    check64($sformatf("c%0d stray_strobes", ci), 64'(stray), 64'd0);
    $display("case %0d ranges %0d ids %0d error %0d done %0d",
             ci, got_rng.size(), got_id.size(), bus.error, bus.done);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    n_cases = 0;
    reset   = 1'b1;

    // 0: reference stream, JTAG-paced, with a separate end_of_input.
    new_case("", "3-5\n10-14\n16-20\n12-18\n\n1\n5\n8\n11\n17\n32\n", 12, 1, 1'b0, 1'b1);
    add_rng(3, 5); add_rng(10, 14); add_rng(16, 20); add_rng(12, 18);
    add_id(1); add_id(5); add_id(8); add_id(11); add_id(17); add_id(32);
    // 1: CRLF line endings and no final newline. The ID 32 comes from the flush.
    new_case("", "3-5\015\n10-14\015\n16-20\015\n12-18\015\n\015\n1\015\n5\015\n8\015\n11\015\n17\015\n32",
             12, 1, 1'b0, 1'b1);
    add_rng(3, 5); add_rng(10, 14); add_rng(16, 20); add_rng(12, 18);
    add_id(1); add_id(5); add_id(8); add_id(11); add_id(17); add_id(32);
    // 2: 2^64 saturates the lower bound and sets error.
    new_case("", "18446744073709551616-1\n", 0, 0, 1'b1, 1'b0);
    add_rng(ALL_ONES, 1);
    // 3: 2^64-1 fits exactly.
    new_case("", "18446744073709551615-0\n", 0, 0, 1'b0, 1'b0);
    add_rng(ALL_ONES, 0);
    // 4: the illegal character is skipped.
    new_case("", "3x-5\n", 12, 0, 1'b1, 1'b0);
    add_rng(3, 5);
    // 5: a leading '-' produces no record.
    new_case("", "-5\n", 12, 0, 1'b1, 1'b0);
    // 6: a reset in the middle of a line discards "12-3".
    new_case("12-3", "7-9\n\n4\n", 12, 0, 1'b0, 1'b1);
    add_rng(7, 9); add_id(4);
    // 7: back-to-back bytes, with end_of_input on the final '\n'.
    new_case("", "1-2\n\n9\n", 0, 2, 1'b0, 1'b1);
    add_rng(1, 2); add_id(9);
    // 8: end_of_input on the last digit. The flushed ID includes that digit.
    new_case("", "1-2\n\n9", 0, 2, 1'b0, 1'b1);
    add_rng(1, 2); add_id(9);
    // 9: the stream starts with a blank line. A blank line between IDs is ignored.
    new_case("", "\n5\n\n7\n", 0, 1, 1'b0, 1'b1);
    add_id(5); add_id(7);
    // 10: lo > hi is passed through unchanged.
    new_case("", "9-3\n", 0, 1, 1'b0, 1'b0);
    add_rng(9, 3);
    // 11: an unterminated range is flushed by end_of_input.
    new_case("", "4-6", 12, 1, 1'b0, 1'b0);
    add_rng(4, 6);

    do_reset();
    check64("reset range_valid", 64'(bus.range_valid), 64'd0);
    check64("reset id_valid", 64'(bus.id_valid), 64'd0);
    check64("reset range_lo", bus.range_lo, 64'd0);
    check64("reset range_hi", bus.range_hi, 64'd0);
    check64("reset id_value", bus.id_value, 64'd0);
    check64("reset ranges_done", 64'(bus.ranges_done), 64'd0);
    check64("reset done", 64'(bus.done), 64'd0);
    check64("reset range_count", 64'(bus.range_count), 64'd0);
    check64("reset id_count", 64'(bus.id_count), 64'd0);
    check64("reset error", 64'(bus.error), 64'd0);

    for (int ci = 0; ci < n_cases; ci++) begin
      run_case(ci);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cafeteria_input_decoder.md
Name: cafeteria_input_decoder

Overview:
- Byte-stream parser for the 2025 day 5 puzzle input (fresh-ID range list, a blank line, then ingredient IDs).
- Sits directly downstream of the JTAG byte deserializer inside user_logic. It consumes one ASCII byte per valid strobe, shifted in LSB-first over USER4.
- Emits decoded range records and ID records to the range-match/count stage, which produces the 64-bit readback result.

Parameters:
- VALUE_WIDTH, 64, width of every decoded decimal value (range bounds and IDs).
- COUNT_WIDTH, 16, width of the range and ID record counters.

Ports:
- tck  in  1  design clock (JTAG TCK domain)
- reset  in  1  synchronous, active-high reset
- byte_valid  in  1  one-cycle strobe: byte_data holds a new input character
- byte_data  in  8  ASCII character
- end_of_input  in  1  one-cycle strobe: no more bytes follow
- range_valid  out  1  one-cycle strobe: range_lo/range_hi hold a completed range
- range_lo  out  VALUE_WIDTH  range lower bound, inclusive
- range_hi  out  VALUE_WIDTH  range upper bound, inclusive
- id_valid  out  1  one-cycle strobe: id_value holds a completed ID
- id_value  out  VALUE_WIDTH  ingredient ID
- ranges_done  out  1  level, set once the blank separator line is seen
- done  out  1  level, set after end_of_input has been processed
- range_count  out  COUNT_WIDTH  number of range records emitted
- id_count  out  COUNT_WIDTH  number of ID records emitted
- error  out  1  sticky: illegal character, misplaced '-', or arithmetic overflow

Behaviour:
- Reset values:
  - All strobes, levels and counters are 0.
  - range_lo, range_hi and id_value are 0.
  - The state machine returns to RANGE_LO.
  - Reset mid-line discards all partial values.
- State machine states: RANGE_LO, RANGE_HI, IDS, DONE.
- Accumulator rules:
  - A digit ('0'..'9') updates acc = acc*10 + digit, computed at VALUE_WIDTH+4 bits.
  - If any bit at or above VALUE_WIDTH is set, acc saturates to all-ones and error is set.
  - line_has_digit tracks whether the current line holds any digit.
- '\r' (0x0D) is ignored in every state.
- RANGE_LO:
  - digit: accumulate.
  - '-' with line_has_digit=1: latch lo <= acc, clear acc, go to RANGE_HI.
  - '-' with no digit: set error, stay in RANGE_LO.
  - '\n' with line_has_digit=0: the blank line. Set ranges_done and go to IDS.
  - '\n' with line_has_digit=1: set error, drop the line, stay in RANGE_LO.
- RANGE_HI:
  - digit: accumulate.
  - '\n': output range_lo <= lo and range_hi <= acc. Pulse range_valid, increment range_count, clear acc, go to RANGE_LO.
  - A range with lo > hi is emitted unchanged; the consumer handles it.
- IDS:
  - digit: accumulate.
  - '\n' with line_has_digit=1: id_value <= acc, pulse id_valid, increment id_count, clear acc.
  - '\n' with no digit: ignored (tolerates blank trailing lines).
- Any other character in any state sets error and is otherwise ignored.
- end_of_input, from any state:
  - A pending ID in IDS or a pending range in RANGE_HI is flushed as if '\n' had arrived.
  - One cycle later, done is set and the state machine moves to DONE.
- DONE: byte_valid is ignored and outputs hold until reset.
- Latency: every record strobe appears exactly 1 tck cycle after the terminating byte.
- Back-pressure: none. The block must accept a byte every cycle, even though the JTAG source delivers at most 1 byte per 13 cycles.
- Simultaneous byte_valid and end_of_input: the byte is processed first. If that byte was a terminator, the flush emits nothing extra, and done rises on the following cycle.
- Counters saturate at all-ones; they do not wrap.
- Stream starting with '\n': treated as an empty range list, so the block goes directly to IDS.

Decomposition:
- Shared package aoc25_5_pkg holds:
  - the parser state enum (RANGE_LO, RANGE_HI, IDS, DONE);
  - the ASCII constants CHAR_LF, CHAR_CR, CHAR_DASH, CHAR_ZERO, CHAR_NINE;
  - a range_t struct {lo, hi} reused by the downstream match stage.
- One sub-module, decimal_accumulator: handles digit/clear inputs, saturating ×10+d, and the overflow flag. It is instantiated once and shared across states.

Test Plan:
- Stream "3-5\n10-14\n16-20\n12-18\n\n1\n5\n8\n11\n17\n32\n" then end_of_input:
  - range_valid fires 4×, with (3,5), (10,14), (16,20), (12,18).
  - id_valid fires 6×, with 1, 5, 8, 11, 17, 32.
  - Final state: range_count=4, id_count=6, done=1, error=0.
- Same stream with "\r\n" line endings and no trailing newline after "32", then end_of_input:
  - Identical records; the ID 32 is flushed on end_of_input.
  - done rises 2 cycles after the strobe.
- "18446744073709551616-1\n": error=1, range_lo=0xFFFF_FFFF_FFFF_FFFF, range_hi=1, range_count=1.
- "3x-5\n" and "-5\n": error=1. In "3x-5\n" the 'x' is ignored, giving range (3,5). "-5\n" yields no range record.
- Reset asserted after "12-3" is streamed, then "7-9\n\n4\n":
  - Exactly one range (7,9) and one ID 4 are emitted.
  - No residue of 12 or 3 appears.
- Back-to-back bytes on every cycle for "1-2\n\n9\n": same records as with JTAG-paced delivery; each strobe occurs 1 cycle after its '\n'.
